// File: rtl/fetch_pc.sv
// fetch_pc: PC sequencer with PCreg1-3 save/jump, IDLE/RUN/HALT Start/Done handshake; FETCH_CYCLE_COUNT_EN adds CycleCount
module fetch_pc #(
  parameter int AW = 10,
  parameter int SAVE_OFFSET = 2
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          JumpEqual,
  input  logic          JumpNotEqual,
  input  logic          OffsetEn,
  input  logic [1:0]    PCRegSelect,
  input  logic          Zero,
  input  logic          Ack,
  output logic [AW-1:0] ProgCtr,
  output logic          Running,
`ifdef FETCH_CYCLE_COUNT_EN
  output logic          Done,
  output logic [15:0]   CycleCount
`else
  output logic          Done
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] pc_q, pc_d, p1_q, p1_d, p2_q, p2_d, p3_q, p3_d, tgt, sv;
  logic taken, save;
  assign taken = |PCRegSelect && ((JumpEqual && Zero) || (JumpNotEqual && !Zero));
  assign save = |PCRegSelect && !JumpEqual && !JumpNotEqual;
  assign tgt = PCRegSelect == 2'd1 ? p1_q : PCRegSelect == 2'd2 ? p2_q : p3_q;
  assign sv = pc_q + (OffsetEn ? AW'(SAVE_OFFSET) : AW'(0));
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    p1_d = p1_q;
    p2_d = p2_q;
    p3_d = p3_q;
    if (Start) begin
      state_d = IDLE;
      pc_d = '0;
    end else if (state_q == IDLE) state_d = RUN;
    else if (state_q == RUN) begin
      if (Ack) state_d = HALT;
      else begin
        pc_d = taken ? tgt : pc_q + AW'(1);
        p1_d = (save && PCRegSelect == 2'd1) ? sv : p1_q;
        p2_d = (save && PCRegSelect == 2'd2) ? sv : p2_q;
        p3_d = (save && PCRegSelect == 2'd3) ? sv : p3_q;
      end
    end
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q <= '0;
      p1_q <= '0;
      p2_q <= '0;
      p3_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      p1_q <= p1_d;
      p2_q <= p2_d;
      p3_q <= p3_d;
    end
  end
  assign ProgCtr = pc_q;
  assign Running = state_q == RUN;
  assign Done = state_q == HALT;
`ifdef FETCH_CYCLE_COUNT_EN
  logic [15:0] cc_q, cc_d;
  always_comb cc_d = (state_q == IDLE && !Start) ? 16'd0 :
                     (state_q == RUN && cc_q != 16'hFFFF) ? cc_q + 16'd1 : cc_q;
  always_ff @(posedge Clk) cc_q <= Reset ? 16'd0 : cc_d;
  assign CycleCount = cc_q;
`endif
endmodule
